ps2_rx_fifo: RTL

//  PS/2 keyboard receiver front end. Samples the raw ps2_clk/ps2_data pins and

---
 rtl/ps2_rx_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_fifo
//  Purpose  : PS/2 keyboard receiver. Synchronises the raw pins, deframes
//             11-bit frames (start, 8 data LSB-first, odd parity, stop) and
//             queues good bytes in a small FIFO popped via ready/nextdata_n.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int                c_depth   = 1 << FIFO_AW;
    localparam int                c_tw      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tw-1:0]   c_tmo_max = c_tw'(TIMEOUT_CYC - 1);
    localparam logic [3:0]        c_last    = 4'd10;

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic [2:0] r_clk_sync;
    logic [1:0] r_dat_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    logic w_fall;
    logic w_bit;

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    // Data is taken from the same synchroniser depth as r_clk_sync[1]
    assign w_bit  = r_dat_sync[1];

    // ------------------------------------------------------------------
    // Deframer and inactivity timeout
    // ------------------------------------------------------------------
    logic [3:0]      r_cnt;
    logic [9:0]      r_shift;
    logic [c_tw-1:0] r_tmo;
    logic            r_frame_err;

    logic w_last;
    logic w_frame_ok;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_last     = w_fall && (r_cnt == c_last);
    // The stop bit is the sample arriving with the final fall
    assign w_frame_ok = ~r_shift[0] & w_bit & (^r_shift[9:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_shift     <= 10'd0;
            r_tmo       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_last & ~w_frame_ok;
            if (w_fall) begin
                r_tmo <= '0;
                if (r_cnt == c_last) begin
                    r_cnt <= 4'd0;
                end else begin
                    r_shift[r_cnt] <= w_bit;
                    r_cnt          <= r_cnt + 4'd1;
                end
            end else if (r_cnt == 4'd0) begin
                r_tmo <= '0;
            end else if (r_tmo == c_tmo_max) begin
                // Abandon the partial frame silently
                r_cnt <= 4'd0;
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;
    logic [7:0]       r_mem [c_depth];
    logic             r_overflow;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    // Full is judged on the pre-pop state, so push-while-full always drops
    assign w_push  = w_last & w_frame_ok & ~w_full;
    assign w_pop   = ~nextdata_n & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_last && w_frame_ok && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= r_shift[8:1];
        end
    end

    assign data      = r_mem[r_rptr[FIFO_AW-1:0]];
    assign ready     = ~w_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
